// File: rtl/dense_mac_batched_if.sv
// Bus bundle for dense_mac_batched.
// Ports (all on the bundle):
//   start, relu_en       : request a run; apply ReLU to that run's outputs
//   x, w, b              : input vector, weight matrix, bias vector (held by the source during a run)
//   y                    : saturated results, held until the next result
//   busy, done           : run in progress; one-cycle result strobe
interface dense_mac_batched_if #(
  parameter int unsigned BITSIZE  = 16,
  parameter int unsigned IN_SIZE  = 92,
  parameter int unsigned OUT_SIZE = 4
);
  logic                                  start;
  logic                                  relu_en;
  logic [BITSIZE*IN_SIZE-1:0]            x;
  logic [BITSIZE*OUT_SIZE*IN_SIZE-1:0]   w;
  logic [BITSIZE*OUT_SIZE-1:0]           b;
  logic [BITSIZE*OUT_SIZE-1:0]           y;
  logic                                  busy;
  logic                                  done;

  modport master (output start, relu_en, x, w, b, input y, busy, done);
  modport slave  (input start, relu_en, x, w, b, output y, busy, done);
endinterface

// File: rtl/dense_mac_batched.sv
// Fixed-point fully-connected layer: y[o] = act(b[o] + sum_i x[i]*w[o][i]),
// BATCH multiplier lanes per output, one batch per cycle.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   bus    : slave side of dense_mac_batched_if (start/relu_en/x/w/b in, y/busy/done out)
module dense_mac_batched #(
  parameter int unsigned BITSIZE  = 16,
  parameter int unsigned FRAC     = 8,
  parameter int unsigned IN_SIZE  = 92,
  parameter int unsigned OUT_SIZE = 4,
  parameter int unsigned BATCH    = 32
) (
  input  logic               clk,
  input  logic               reset,
  dense_mac_batched_if.slave bus
);

  localparam int unsigned BATCH_COUNT = (IN_SIZE + BATCH - 1) / BATCH;
  localparam int unsigned ACC_W       = 2 * BITSIZE + $clog2(IN_SIZE + 1);
  localparam int unsigned PROD_W      = 2 * BITSIZE;
  localparam int unsigned IDX_W       = $clog2(BATCH_COUNT + 2);
  localparam int unsigned HI_W        = ACC_W - BITSIZE + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FILL   = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  logic [1:0]               r_state;
  logic [1:0]               w_state_nx;
  logic [IDX_W-1:0]         r_batch_idx;
  logic                     r_relu;
  logic                     r_busy;
  logic                     r_done;
  logic [BITSIZE*OUT_SIZE-1:0] r_y;
  logic signed [ACC_W-1:0]  r_acc     [OUT_SIZE];
  logic signed [PROD_W-1:0] r_mul     [OUT_SIZE][BATCH];
  logic                     r_lane_ok [BATCH];

  int unsigned              w_idx     [BATCH];
  logic                     w_lane_ok [BATCH];
  logic signed [BITSIZE-1:0] w_x      [BATCH];
  logic signed [BITSIZE-1:0] w_wt     [OUT_SIZE][BATCH];
  logic signed [PROD_W-1:0] w_full    [OUT_SIZE][BATCH];
  logic signed [PROD_W-1:0] w_prod    [OUT_SIZE][BATCH];
  logic signed [ACC_W-1:0]  w_sum     [OUT_SIZE];
  logic [HI_W-1:0]          w_hi      [OUT_SIZE];
  logic [BITSIZE-1:0]       w_y       [OUT_SIZE];

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  // Next-state logic; FINISH follows the RUN cycle that adds the last batch
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:   if (bus.start) w_state_nx = S_FILL;
      S_FILL:   w_state_nx = S_RUN;
      S_RUN:    if (r_batch_idx == IDX_W'(BATCH_COUNT)) w_state_nx = S_FINISH;
      S_FINISH: w_state_nx = S_IDLE;
      default:  w_state_nx = S_IDLE;
    endcase
  end

  // Lane operand mux and products for batch r_batch_idx; padding lanes read zero
  always_comb begin
    for (int unsigned k = 0; k < BATCH; k++) begin
      w_idx[k]     = 32'(r_batch_idx) * BATCH + k;
      w_lane_ok[k] = w_idx[k] < IN_SIZE;
      if (!w_lane_ok[k]) w_idx[k] = 0;
      w_x[k] = w_lane_ok[k] ? bus.x[w_idx[k]*BITSIZE +: BITSIZE] : '0;
      for (int unsigned o = 0; o < OUT_SIZE; o++) begin
        w_wt[o][k]   = w_lane_ok[k] ? bus.w[(o*IN_SIZE + w_idx[k])*BITSIZE +: BITSIZE] : '0;
        w_full[o][k] = PROD_W'(w_x[k]) * PROD_W'(w_wt[o][k]);
        w_prod[o][k] = w_full[o][k] >>> FRAC;
      end
    end
  end

  // Batch sum; lanes flagged past the end of the vector are masked again here
  always_comb begin
    for (int unsigned o = 0; o < OUT_SIZE; o++) begin
      w_sum[o] = '0;
      for (int unsigned k = 0; k < BATCH; k++) begin
        if (r_lane_ok[k]) w_sum[o] = w_sum[o] + ACC_W'(r_mul[o][k]);
      end
    end
  end

  // Output saturation (upper bits must all match the sign) then optional ReLU
  always_comb begin
    for (int unsigned o = 0; o < OUT_SIZE; o++) begin
      w_hi[o] = r_acc[o][ACC_W-1:BITSIZE-1];
      if ((&w_hi[o]) || !(|w_hi[o])) w_y[o] = r_acc[o][BITSIZE-1:0];
      else if (r_acc[o][ACC_W-1])    w_y[o] = {1'b1, {(BITSIZE-1){1'b0}}};
      else                           w_y[o] = {1'b0, {(BITSIZE-1){1'b1}}};
      if (r_relu && w_y[o][BITSIZE-1]) w_y[o] = '0;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_batch_idx <= '0;
      r_relu      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_y         <= '0;
      for (int unsigned o = 0; o < OUT_SIZE; o++) begin
        r_acc[o] <= '0;
        for (int unsigned k = 0; k < BATCH; k++) r_mul[o][k] <= '0;
      end
      for (int unsigned k = 0; k < BATCH; k++) r_lane_ok[k] <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_busy <= bus.start;
          if (bus.start) r_relu <= bus.relu_en;
        end
        S_FILL, S_RUN: begin
          for (int unsigned o = 0; o < OUT_SIZE; o++) begin
            r_acc[o] <= (r_state == S_FILL) ? ACC_W'($signed(bus.b[o*BITSIZE +: BITSIZE]))
                                            : r_acc[o] + w_sum[o];
            for (int unsigned k = 0; k < BATCH; k++) r_mul[o][k] <= w_prod[o][k];
          end
          for (int unsigned k = 0; k < BATCH; k++) r_lane_ok[k] <= w_lane_ok[k];
          r_batch_idx <= r_batch_idx + IDX_W'(1);
        end
        S_FINISH: begin
          for (int unsigned o = 0; o < OUT_SIZE; o++) r_y[o*BITSIZE +: BITSIZE] <= w_y[o];
          r_done      <= 1'b1;
          r_batch_idx <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.y    = r_y;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule
